// File: rtl/cec_msg_sequencer.sv
// cec_msg_sequencer: serialises one CEC frame (header, opcode, operand bytes)
// towards a byte-wise line driver. Rejected bytes cause a timed back-off and a
// full re-send from the header; an abort or exhausted retries end in error.
module cec_msg_sequencer #(
    parameter int         MAX_PARAMS  = 4,
    parameter int         MAX_RETRIES = 2,
    parameter int         RETRY_GAP   = 16,
    parameter logic [3:0] SRC_ADDR    = 4'd14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             trigger,
    input  logic                             abort,
    input  logic [3:0]                       dst_addr,
    input  logic [7:0]                       op_code,
    input  logic [$clog2(MAX_PARAMS+1)-1:0]  param_count,
    input  logic [8*MAX_PARAMS-1:0]          params,
    input  logic                             data_acknowledged,
    input  logic                             data_rejected,
    output logic [7:0]                       data_out,
    output logic                             data_eom,
    output logic                             data_broadcast,
    output logic                             data_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);
    localparam int PCW = $clog2(MAX_PARAMS + 1);
    localparam int RCW = $clog2(MAX_RETRIES + 1);
    localparam int GW  = $clog2(RETRY_GAP + 1);

    localparam logic [PCW-1:0] PC_MAX   = PCW'(MAX_PARAMS);
    localparam logic [RCW-1:0] RC_MAX   = RCW'(MAX_RETRIES);
    localparam logic [GW-1:0]  GAP_LAST = GW'(RETRY_GAP - 1);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] SEND_HEADER  = 3'd1;
    localparam logic [2:0] SEND_OP_CODE = 3'd2;
    localparam logic [2:0] SEND_PARAMS  = 3'd3;
    localparam logic [2:0] RETRY_WAIT   = 3'd4;

    logic [2:0]              state;
    logic [3:0]              dst_q;
    logic [7:0]              op_q;
    logic [8*MAX_PARAMS-1:0] params_q;
    logic [PCW-1:0]          pc_q;
    logic                    bcast_q;
    logic [PCW-1:0]          idx;
    logic [PCW-1:0]          idx_nxt;
    logic [GW-1:0]           gap;

    // Operand byte selected by index; a loop keeps the select width-exact.
    function automatic logic [7:0] param_byte(input logic [8*MAX_PARAMS-1:0] p,
                                              input logic [PCW-1:0] i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < MAX_PARAMS; k++) begin
            if (PCW'(k) == i) b = p[8*k +: 8];
        end
        return b;
    endfunction

    assign idx_nxt = idx + 1'b1;

    // Broadcast flag is only meaningful while a message is in flight.
    assign data_broadcast = busy & bcast_q;

    // Message sequencing: latch, present bytes, handle handshake, retry and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            data_out    <= 8'h00;
            data_eom    <= 1'b0;
            data_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            retry_count <= '0;
            bcast_q     <= 1'b0;
            idx         <= '0;
            gap         <= '0;
        end else begin
            data_ready <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                data_out <= 8'h00;
                data_eom <= 1'b0;
                error    <= 1'b1;
            end else if (state == IDLE) begin
                // busy covers the done/error cycle, so it also blocks a trigger there
                busy <= 1'b0;
                if (trigger && !busy) begin
                    dst_q       <= dst_addr;
                    op_q        <= op_code;
                    params_q    <= params;
                    pc_q        <= (param_count > PC_MAX) ? PC_MAX : param_count;
                    bcast_q     <= (dst_addr == 4'hF);
                    retry_count <= '0;
                    busy        <= 1'b1;
                    data_out    <= {SRC_ADDR, dst_addr};
                    data_eom    <= 1'b0;
                    data_ready  <= 1'b1;
                    state       <= SEND_HEADER;
                end
            end else if (state == RETRY_WAIT) begin
                if (gap == GAP_LAST) begin
                    data_out   <= {SRC_ADDR, dst_q};
                    data_eom   <= 1'b0;
                    data_ready <= 1'b1;
                    state      <= SEND_HEADER;
                end else begin
                    gap <= gap + 1'b1;
                end
            end else if (data_rejected) begin
                // a reject wins over a simultaneous ack
                if (retry_count < RC_MAX) begin
                    retry_count <= retry_count + 1'b1;
                    gap         <= '0;
                    state       <= RETRY_WAIT;
                end else begin
                    state    <= IDLE;
                    data_out <= 8'h00;
                    data_eom <= 1'b0;
                    error    <= 1'b1;
                end
            end else if (data_acknowledged) begin
                if (state == SEND_HEADER) begin
                    data_out   <= op_q;
                    data_eom   <= (pc_q == '0);
                    data_ready <= 1'b1;
                    state      <= SEND_OP_CODE;
                end else if ((state == SEND_OP_CODE && pc_q == '0) ||
                             (state == SEND_PARAMS && idx == pc_q - 1'b1)) begin
                    state    <= IDLE;
                    data_out <= 8'h00;
                    data_eom <= 1'b0;
                    done     <= 1'b1;
                end else if (state == SEND_OP_CODE) begin
                    idx        <= '0;
                    data_out   <= param_byte(params_q, '0);
                    data_eom   <= (pc_q == PCW'(1));
                    data_ready <= 1'b1;
                    state      <= SEND_PARAMS;
                end else begin
                    idx        <= idx_nxt;
                    data_out   <= param_byte(params_q, idx_nxt);
                    data_eom   <= (idx_nxt == pc_q - 1'b1);
                    data_ready <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cec_msg_sequencer.sv
// Bench for cec_msg_sequencer: each scenario is expanded from its byte list and
// handshake script into an expected cycle-by-cycle trace, which is then played
// against the DUT; byte streams and retry counts are also pinned to literals.
module tb_cec_msg_sequencer;
    localparam int MAXP = 4;
    localparam int MAXR = 2;
    localparam int GAP  = 16;

    localparam int K_ACK   = 0;
    localparam int K_REJ   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_ABORT = 3;
    localparam int K_RST   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  dst_addr = '0;
    logic [7:0]  op_code = '0;
    logic [2:0]  param_count = '0;
    logic [31:0] params = '0;
    logic        data_acknowledged = 1'b0;
    logic        data_rejected = 1'b0;
    logic [7:0]  data_out;
    logic        data_eom, data_broadcast, data_ready, busy, done, error;
    logic [1:0]  retry_count;

    always #5 clk = ~clk;

    cec_msg_sequencer #(
        .MAX_PARAMS(MAXP), .MAX_RETRIES(MAXR), .RETRY_GAP(GAP), .SRC_ADDR(4'd14)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort),
        .dst_addr(dst_addr), .op_code(op_code), .param_count(param_count),
        .params(params), .data_acknowledged(data_acknowledged),
        .data_rejected(data_rejected), .data_out(data_out), .data_eom(data_eom),
        .data_broadcast(data_broadcast), .data_ready(data_ready), .busy(busy),
        .done(done), .error(error), .retry_count(retry_count)
    );

    typedef struct packed {
        logic        chk;
        logic        rst, trig, ab, ak, rj;
        logic [3:0]  dst;
        logic [7:0]  op;
        logic [2:0]  pc;
        logic [31:0] prm;
        logic [7:0]  dout;
        logic        eom, bc, rdy, bsy, dn, er;
        logic [1:0]  rc;
    } cyc_t;

    typedef struct packed {
        int d;
        int k;
    } resp_t;

    cyc_t       tl[$];
    resp_t      rq[$];
    logic [7:0] cap[$];
    logic [7:0] want[$];
    int         played = 0;
    int         checks = 0;
    int         errors = 0;
    int         dn_cnt = 0;
    int         er_cnt = 0;
    logic [1:0] m_retry = '0;

    // Idle cycle: nothing asserted, message inputs hold junk that must be ignored.
    function automatic cyc_t base();
        cyc_t c;
        c      = '0;
        c.chk  = 1'b1;
        c.dst  = 4'($urandom);
        c.op   = 8'($urandom);
        c.pc   = 3'($urandom);
        c.prm  = $urandom;
        c.rc   = m_retry;
        return c;
    endfunction

    task automatic resp(input int d, input int k);
        resp_t r;
        r.d = d;
        r.k = k;
        rq.push_back(r);
    endtask

    // Expand one message and its response script into the expected trace.
    task automatic gen_msg(input logic [3:0] dst, input logic [7:0] op,
                           input logic [2:0] pc, input logic [31:0] prm);
        logic [7:0] bytes[$];
        int         npc, last, k;
        cyc_t       c;
        resp_t      r;
        logic       bc, finished, restart;
        npc = (int'(pc) > MAXP) ? MAXP : int'(pc);
        bytes.push_back({4'hE, dst});
        bytes.push_back(op);
        for (int i = 0; i < npc; i++) bytes.push_back(prm[8*i +: 8]);
        last = bytes.size() - 1;
        bc = (dst == 4'hF);
        c = base();
        c.trig = 1'b1; c.dst = dst; c.op = op; c.pc = pc; c.prm = prm;
        tl.push_back(c);
        m_retry = '0;
        finished = 1'b0;
        while (!finished) begin
            restart = 1'b0;
            k = 0;
            while (k <= last && !finished && !restart) begin
                r = rq.pop_front();
                for (int j = 0; j <= r.d; j++) begin
                    c = base();
                    c.dout = bytes[k]; c.eom = (k == last); c.bc = bc; c.bsy = 1'b1;
                    c.rdy = (j == 0);
                    c.trig = (j == 1);
                    if (j == r.d) begin
                        case (r.k)
                            K_ACK:   c.ak = 1'b1;
                            K_REJ:   c.rj = 1'b1;
                            K_BOTH:  begin c.ak = 1'b1; c.rj = 1'b1; end
                            K_ABORT: c.ab = 1'b1;
                            default: begin c.rst = 1'b1; c.trig = 1'b1; end
                        endcase
                    end
                    tl.push_back(c);
                end
                case (r.k)
                    K_ACK: begin
                        if (k == last) begin
                            c = base(); c.bc = bc; c.bsy = 1'b1; c.dn = 1'b1;
                            tl.push_back(c);
                            finished = 1'b1;
                        end
                    end
                    K_REJ, K_BOTH: begin
                        if (int'(m_retry) < MAXR) begin
                            m_retry = m_retry + 2'd1;
                            for (int g = 0; g < GAP; g++) begin
                                c = base();
                                c.dout = bytes[k]; c.eom = (k == last); c.bc = bc; c.bsy = 1'b1;
                                tl.push_back(c);
                            end
                            restart = 1'b1;
                        end else begin
                            c = base(); c.bc = bc; c.bsy = 1'b1; c.er = 1'b1;
                            tl.push_back(c);
                            finished = 1'b1;
                        end
                    end
                    K_ABORT: begin
                        c = base(); c.bc = bc; c.bsy = 1'b1; c.er = 1'b1;
                        tl.push_back(c);
                        finished = 1'b1;
                    end
                    default: begin
                        m_retry = '0;
                        finished = 1'b1;
                    end
                endcase
                k++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            c = base();
            c.ab = (i == 0);
            tl.push_back(c);
        end
    endtask

    // Play the trace: check outputs #1 after each edge, then drive that cycle's inputs.
    task automatic play();
        cyc_t c;
        while (played < tl.size()) begin
            c = tl[played];
            @(posedge clk);
            #1;
            if (c.chk) begin
                checks++;
                if ({data_out, data_eom, data_broadcast, data_ready, busy, done, error, retry_count} !==
                    {c.dout, c.eom, c.bc, c.rdy, c.bsy, c.dn, c.er, c.rc}) begin
                    errors++;
                    $display("FAIL cycle %0d: got out=%h eom=%b bc=%b rdy=%b busy=%b done=%b err=%b rc=%0d, want out=%h eom=%b bc=%b rdy=%b busy=%b done=%b err=%b rc=%0d",
                             played, data_out, data_eom, data_broadcast, data_ready, busy, done, error, retry_count,
                             c.dout, c.eom, c.bc, c.rdy, c.bsy, c.dn, c.er, c.rc);
                end
            end
            if (data_ready) cap.push_back(data_out);
            if (done) dn_cnt++;
            if (error) er_cnt++;
            rst = c.rst; trigger = c.trig; abort = c.ab;
            data_acknowledged = c.ak; data_rejected = c.rj;
            dst_addr = c.dst; op_code = c.op; param_count = c.pc; params = c.prm;
            played++;
        end
    endtask

    task automatic new_scn();
        cap.delete();
        want.delete();
        dn_cnt = 0;
        er_cnt = 0;
    endtask

    task automatic chk_cap(input string name);
        logic ok;
        ok = (cap.size() == want.size());
        for (int i = 0; ok && i < cap.size(); i++) if (cap[i] !== want[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d bytes %p, want %0d bytes %p", name, cap.size(), cap, want.size(), want);
        end
    endtask

    task automatic chk_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    initial begin
        cyc_t c;
        c = base(); c.rst = 1'b1;
        tl.push_back(c); tl.push_back(c);
        c = base(); tl.push_back(c);
        play();

        // Plain opcode, no operands, acks two cycles late
        new_scn();
        resp(2, K_ACK); resp(2, K_ACK);
        gen_msg(4'd0, 8'h04, 3'd0, 32'h0);
        play();
        want.push_back(8'hE0); want.push_back(8'h04);
        chk_cap("s1 bytes");
        chk_val("s1 done pulses", dn_cnt, 1);

        // Broadcast with two operands
        new_scn();
        resp(0, K_ACK); resp(1, K_ACK); resp(2, K_ACK); resp(3, K_ACK);
        gen_msg(4'd15, 8'h82, 3'd2, 32'h0000_0010);
        play();
        want.push_back(8'hEF); want.push_back(8'h82); want.push_back(8'h10); want.push_back(8'h00);
        chk_cap("s2 bytes");

        // Opcode rejected once, then success
        new_scn();
        resp(1, K_ACK); resp(1, K_REJ); resp(0, K_ACK); resp(2, K_ACK);
        gen_msg(4'd0, 8'h44, 3'd0, 32'h0);
        play();
        want.push_back(8'hE0); want.push_back(8'h44); want.push_back(8'hE0); want.push_back(8'h44);
        chk_cap("s3 bytes");
        chk_val("s3 retry_count", int'(retry_count), 1);
        chk_val("s3 done pulses", dn_cnt, 1);

        // Every header rejected: retries exhausted
        new_scn();
        resp(0, K_REJ); resp(1, K_REJ); resp(0, K_REJ);
        gen_msg(4'd3, 8'h36, 3'd1, 32'h0000_0077);
        play();
        want.push_back(8'hE3); want.push_back(8'hE3); want.push_back(8'hE3);
        chk_cap("s4 bytes");
        chk_val("s4 retry_count", int'(retry_count), 2);
        chk_val("s4 done pulses", dn_cnt, 0);
        chk_val("s4 error pulses", er_cnt, 1);

        // Ack+reject together on header, then abort during operands
        new_scn();
        resp(1, K_BOTH); resp(0, K_ACK); resp(0, K_ACK); resp(1, K_ACK); resp(1, K_ABORT);
        gen_msg(4'd5, 8'h9F, 3'd3, 32'h0033_2211);
        play();
        chk_val("s5 retry_count", int'(retry_count), 1);
        chk_val("s5 error pulses", er_cnt, 1);
        chk_val("s5 done pulses", dn_cnt, 0);

        // Reset during operands, with trigger asserted alongside
        new_scn();
        resp(0, K_ACK); resp(0, K_ACK); resp(1, K_RST);
        gen_msg(4'd1, 8'h11, 3'd2, 32'h0000_2211);
        play();
        chk_val("s6 retry_count", int'(retry_count), 0);
        chk_val("s6 data_out", int'(data_out), 0);
        chk_val("s6 done+error pulses", dn_cnt + er_cnt, 0);

        // Operand count above the maximum is clamped
        new_scn();
        for (int i = 0; i < 6; i++) resp(0, K_ACK);
        gen_msg(4'd4, 8'h20, 3'd7, 32'hDDCC_BBAA);
        play();
        want.push_back(8'hE4); want.push_back(8'h20); want.push_back(8'hAA);
        want.push_back(8'hBB); want.push_back(8'hCC); want.push_back(8'hDD);
        chk_cap("s7 bytes");

        // Last operand rejected twice, third attempt succeeds
        new_scn();
        resp(0, K_ACK); resp(0, K_ACK); resp(1, K_REJ);
        resp(0, K_ACK); resp(0, K_ACK); resp(0, K_REJ);
        resp(0, K_ACK); resp(0, K_ACK); resp(2, K_ACK);
        gen_msg(4'd2, 8'h33, 3'd1, 32'h0000_0055);
        play();
        chk_val("s8 retry_count", int'(retry_count), 2);
        chk_val("s8 done pulses", dn_cnt, 1);
        chk_val("s8 byte count", cap.size(), 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
